// File: rtl/gpr_scoreboard.sv
// Register-hazard scoreboard for decode: per-GPR pending-write counters,
// RAW stall generation for NSRC operands and NWB write-back retire ports.
module gpr_scoreboard #(
  parameter int NREG         = 32,
  parameter int CNT_W        = 2,
  parameter int NSRC         = 2,
  parameter int NWB          = 1,
  parameter int MAX_INFLIGHT = 4,
  parameter int BYPASS_WB    = 1,
  localparam int AW          = $clog2(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic [NSRC-1:0]     src_need,
  input  logic [NSRC*AW-1:0]  src_idx,
  output logic [NSRC-1:0]     src_busy,
  output logic                raw_stall,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*AW-1:0]   wb_rd,
  output logic [7:0]          inflight,
  output logic                empty,
  output logic                underflow_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [7:0]       MAX_T   = 8'(MAX_INFLIGHT);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [7:0]       total_q, total_d;
  logic             err_q;
  logic             uf_set;
  logic             issue_acc;
  logic [AW-1:0]    wb_rd_a  [NWB];
  logic [AW-1:0]    src_idx_a [NSRC];

  always_comb begin
    for (int j = 0; j < NWB; j++) wb_rd_a[j] = wb_rd[j*AW +: AW];
    for (int k = 0; k < NSRC; k++) src_idx_a[k] = src_idx[k*AW +: AW];
  end

  // Same-cycle retires deliberately do not free capacity here, keeping wb off the ready path.
  assign issue_ready = (issue_rd == '0) |
                       ((cnt_q[issue_rd] != CNT_MAX) & (total_q < MAX_T));
  assign issue_acc   = issue_valid & issue_ready & (issue_rd != '0);

  always_comb begin
    cnt_d   = cnt_q;
    total_d = total_q;
    uf_set  = 1'b0;
    if (flush) begin
      for (int r = 0; r < NREG; r++) cnt_d[r] = '0;
      total_d = '0;
    end else begin
      if (issue_acc) begin
        cnt_d[issue_rd] = cnt_d[issue_rd] + CNT_ONE;
        total_d         = total_d + 8'd1;
      end
      // Issue is applied first so an issue/retire pair on an idle register cancels.
      for (int j = 0; j < NWB; j++) begin
        if (wb_valid[j] && (wb_rd_a[j] != '0)) begin
          if (cnt_d[wb_rd_a[j]] == '0) begin
            uf_set = 1'b1;
          end else begin
            cnt_d[wb_rd_a[j]] = cnt_d[wb_rd_a[j]] - CNT_ONE;
            total_d           = total_d - 8'd1;
          end
        end
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      total_q <= total_d;
      err_q   <= err_q | uf_set;
    end
  end

  always_comb begin
    int nret;
    for (int k = 0; k < NSRC; k++) begin
      nret = 0;
      for (int j = 0; j < NWB; j++) begin
        if (wb_valid[j] && (wb_rd_a[j] != '0) && (wb_rd_a[j] == src_idx_a[k])) nret = nret + 1;
      end
      if (BYPASS_WB != 0)
        src_busy[k] = src_need[k] && (src_idx_a[k] != '0) && (int'(cnt_q[src_idx_a[k]]) > nret);
      else
        src_busy[k] = src_need[k] && (src_idx_a[k] != '0) && (cnt_q[src_idx_a[k]] != '0);
    end
  end

  assign raw_stall     = |src_busy;
  assign inflight      = total_q;
  assign empty         = (total_q == '0);
  assign underflow_err = err_q;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Scoreboard bench for gpr_scoreboard: directed hazard scenarios then random
// traffic, checked against an array-based model of the pending-write rules.
module tb_gpr_scoreboard;
  localparam int NREG = 32, CNT_W = 2, NSRC = 2, NWB = 2, MAXI = 4, BYP = 1;
  localparam int AW = $clog2(NREG);
  localparam int CMAX = (1 << CNT_W) - 1;

  logic                clock = 1'b0;
  logic                reset, flush, issue_valid, issue_ready, raw_stall, empty, underflow_err;
  logic [NSRC-1:0]     src_need, src_busy;
  logic [NSRC*AW-1:0]  src_idx;
  logic [AW-1:0]       issue_rd;
  logic [NWB-1:0]      wb_valid;
  logic [NWB*AW-1:0]   wb_rd;
  logic [7:0]          inflight;

  gpr_scoreboard #(.NREG(NREG), .CNT_W(CNT_W), .NSRC(NSRC), .NWB(NWB),
                   .MAX_INFLIGHT(MAXI), .BYPASS_WB(BYP)) dut (
    .clock(clock), .reset(reset), .flush(flush), .src_need(src_need), .src_idx(src_idx),
    .src_busy(src_busy), .raw_stall(raw_stall), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .inflight(inflight), .empty(empty), .underflow_err(underflow_err));

  always #5 clock = ~clock;

  typedef struct {
    logic [NSRC-1:0] busy;
    logic            stall;
    logic            rdy;
    logic [7:0]      infl;
    logic            emp;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt[NREG];
  int   m_total;
  bit   m_err;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_total = 0;
    m_err   = 1'b0;
  endtask

  // Inputs are already driven; record expected outputs, advance the model, clock.
  task automatic cyc(input int i0, input int i1, input int ird, input int w0, input int w1);
    exp_t e;
    int   idx[NSRC];
    int   wr[NWB];
    int   nret;
    idx[0] = i0; idx[1] = i1;
    wr[0]  = w0; wr[1]  = w1;
    e.rdy = (ird == 0) || (m_cnt[ird] < CMAX && m_total < MAXI);
    for (int k = 0; k < NSRC; k++) begin
      nret = 0;
      for (int j = 0; j < NWB; j++) if (wb_valid[j] && wr[j] != 0 && wr[j] == idx[k]) nret++;
      if (BYP != 0) e.busy[k] = src_need[k] && idx[k] != 0 && m_cnt[idx[k]] > nret;
      else          e.busy[k] = src_need[k] && idx[k] != 0 && m_cnt[idx[k]] > 0;
    end
    e.stall = |e.busy;
    e.infl  = 8'(m_total);
    e.emp   = (m_total == 0);
    e.err   = m_err;
    exp_q.push_back(e);
    if (flush) begin
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      m_total = 0;
    end else begin
      if (issue_valid && e.rdy && ird != 0) begin m_cnt[ird]++; m_total++; end
      for (int j = 0; j < NWB; j++) begin
        if (wb_valid[j] && wr[j] != 0) begin
          if (m_cnt[wr[j]] == 0) m_err = 1'b1;
          else begin m_cnt[wr[j]]--; m_total--; end
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] need, input int i0, input int i1,
                       input logic iv, input int ird,
                       input logic [1:0] wv, input int w0, input int w1, input logic fl);
    src_need    = need;
    src_idx     = {AW'(i1), AW'(i0)};
    issue_valid = iv;
    issue_rd    = AW'(ird);
    wb_valid    = wv;
    wb_rd       = {AW'(w1), AW'(w0)};
    flush       = fl;
    cyc(i0, i1, ird, w0, w1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_need = '0; src_idx = '0; issue_valid = 1'b0; issue_rd = '0;
    wb_valid = '0; wb_rd = '0; flush = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (src_busy !== e.busy) begin miscompares++; $display("FAIL src_busy got %b exp %b t=%0t", src_busy, e.busy, $time); end
      if (raw_stall !== e.stall) begin miscompares++; $display("FAIL raw_stall got %b exp %b t=%0t", raw_stall, e.stall, $time); end
      if (issue_ready !== e.rdy) begin miscompares++; $display("FAIL issue_ready got %b exp %b t=%0t", issue_ready, e.rdy, $time); end
      if (inflight !== e.infl) begin miscompares++; $display("FAIL inflight got %0d exp %0d t=%0t", inflight, e.infl, $time); end
      if (empty !== e.emp) begin miscompares++; $display("FAIL empty got %b exp %b t=%0t", empty, e.emp, $time); end
      if (underflow_err !== e.err) begin miscompares++; $display("FAIL underflow_err got %b exp %b t=%0t", underflow_err, e.err, $time); end
    end
  end

  initial begin
    do_reset();
    drive(2'b11, 5, 0, 0, 0, 2'b00, 0, 0, 0);       // reset state
    // single hazard, same-cycle bypass on retire
    drive(2'b00, 0, 0, 1, 5, 2'b00, 0, 0, 0);
    drive(2'b01, 5, 0, 0, 0, 2'b00, 0, 0, 0);
    drive(2'b01, 5, 0, 0, 0, 2'b01, 5, 0, 0);
    drive(2'b01, 5, 0, 0, 0, 2'b00, 0, 0, 0);
    // per-register saturation
    repeat (3) drive(2'b10, 0, 3, 1, 3, 2'b00, 0, 0, 0);
    drive(2'b10, 0, 3, 1, 3, 2'b00, 0, 0, 0);
    drive(2'b10, 0, 3, 1, 3, 2'b01, 3, 0, 0);
    drive(2'b10, 0, 3, 1, 3, 2'b00, 0, 0, 0);
    // global inflight cap
    do_reset();
    for (int r = 1; r <= 4; r++) drive(2'b00, 0, 0, 1, r, 2'b00, 0, 0, 0);
    drive(2'b11, 4, 6, 1, 6, 2'b00, 0, 0, 0);
    drive(2'b11, 1, 2, 1, 0, 2'b00, 0, 0, 0);
    // issue/retire cancel on idle register, src 0 never busy
    do_reset();
    drive(2'b11, 7, 0, 1, 7, 2'b01, 7, 0, 0);
    drive(2'b11, 7, 0, 0, 0, 2'b00, 0, 0, 0);
    // flush drops pending and the concurrent issue; late retire underflows
    drive(2'b00, 0, 0, 1, 8, 2'b00, 0, 0, 0);
    drive(2'b11, 8, 9, 1, 9, 2'b00, 0, 0, 0);
    drive(2'b11, 8, 9, 1, 10, 2'b00, 0, 0, 1);
    drive(2'b11, 8, 10, 0, 0, 2'b00, 0, 0, 0);
    drive(2'b01, 8, 0, 0, 0, 2'b01, 8, 0, 0);
    repeat (2) drive(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    // dual retire ports to one register, then with an underflow on port 1
    do_reset();
    repeat (2) drive(2'b00, 0, 0, 1, 4, 2'b00, 0, 0, 0);
    drive(2'b01, 4, 0, 0, 0, 2'b11, 4, 4, 0);
    drive(2'b01, 4, 0, 1, 4, 2'b00, 0, 0, 0);
    drive(2'b01, 4, 0, 0, 0, 2'b11, 4, 4, 0);
    drive(2'b01, 4, 0, 0, 0, 2'b00, 0, 0, 0);

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] wv;
      int         wr[NWB];
      if (n == 1500) do_reset();
      for (int j = 0; j < NWB; j++) begin
        wr[j] = $urandom_range(1, 7);
        if (m_cnt[wr[j]] > 0) wv[j] = ($urandom_range(0, 9) < 6);
        else                  wv[j] = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 15) == 0) wr[j] = 0;
      end
      drive(2'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
            ($urandom_range(0, 9) < 6), $urandom_range(0, 7),
            wv, wr[0], wr[1], ($urandom_range(0, 49) == 0));
    end

    @(posedge clock);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gpr_scoreboard.md
Name: gpr_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the decode stage. It is the successor to the single-entry "EXU pending rd" compare.
- Holds a per-register pending-write counter, so several writes can be in flight across a deeper EXU/LSU/WBU pipeline.
- Checks NSRC decode source operands against these counters and produces a RAW stall.
- Accepts NWB write-back retirements per cycle.
- Sits beside decode: decode issues a destination here when it hands an instruction to EXU; write-back ports retire it.

Parameters:
- NREG, 32: number of architectural GPRs; power of two. AW = $clog2(NREG).
- CNT_W, 2: width of each per-register counter. Maximum pending writes per register = 2^CNT_W - 1.
- NSRC, 2: number of source operands checked per cycle.
- NWB, 1: number of write-back retire ports.
- MAX_INFLIGHT, 4: cap on total outstanding tracked writes. Range 1..255.
- BYPASS_WB, 1: when 1, a retire in the current cycle clears busy in the same cycle (combinational forward). When 0, busy clears the cycle after the retire.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  clears all pending state
- src_need  in  NSRC  per-source "operand used" flag
- src_idx  in  NSRC*AW  source register indices, packed; src k is at [k*AW +: AW]
- src_busy  out  NSRC  per-source hazard
- raw_stall  out  1  OR of src_busy
- issue_valid  in  1  decode hands an instruction with a destination to EXU
- issue_rd  in  AW  destination register; 0 means no write
- issue_ready  out  1  scoreboard can record the issue
- wb_valid  in  NWB  retire strobes
- wb_rd  in  NWB*AW  retired destinations, packed
- inflight  out  8  total outstanding tracked writes
- empty  out  1  inflight == 0
- underflow_err  out  1  sticky: a retire arrived for a register whose count is 0

Behaviour:
- State: cnt[r] (CNT_W bits) for r = 1..NREG-1, plus total (8 bits). Register 0 is never tracked; its cnt reads as 0.
- Reset: all cnt = 0, total = 0, underflow_err = 0. Resulting outputs: issue_ready = 1, empty = 1, src_busy = 0, raw_stall = 0.
- Issue acceptance: an issue is accepted when issue_valid & issue_ready & (issue_rd != 0). An issue with issue_rd == 0 is accepted trivially and changes no state.
- issue_ready is combinational: issue_ready = (issue_rd == 0) | ((cnt[issue_rd] != 2^CNT_W-1) & (total < MAX_INFLIGHT)).
  - A retire in the same cycle does NOT free capacity for that cycle's issue. This avoids a wb -> issue_ready combinational path.
- Retire: a retire is valid when wb_valid[j] & (wb_rd[j] != 0).
  - It decrements cnt[wb_rd[j]] and total.
  - If the count is already 0 (after counting earlier ports in the same cycle), the decrement for that port is dropped and underflow_err is set. underflow_err stays 1 until reset.
- Per-cycle update: cnt'[r] = cnt[r] + inc[r] - dec[r].
  - inc[r] is 0 or 1 (from issue); dec[r] is 0..NWB (from retires).
  - Evaluation order: issue first, then retire ports 0..NWB-1. An issue and a retire to the same register in the same cycle therefore cancel (net 0), even when cnt was 0.
  - total' = total + accepted_issue - applied_retires.
- Hazard output: src_busy[k] = src_need[k] & (src_idx[k] != 0) & busy(src_idx[k]).
  - BYPASS_WB = 0: busy(r) = cnt[r] != 0.
  - BYPASS_WB = 1: busy(r) = (cnt[r] - retires_to_r_this_cycle) != 0.
  - The same-cycle issue never counts toward busy; decode only checks operands of the instruction it is issuing, whose own rd must not self-stall.
- flush: on the next edge, all cnt = 0 and total = 0.
  - Issue and retire strobes in the flush cycle are ignored.
  - underflow_err is not cleared.
  - Late retires of flushed instructions after this point hit count 0 and set underflow_err. The integrator must gate retires of flushed ops.
- Saturation guards: cnt never wraps above max (blocked by issue_ready) and never goes below 0 (underflow drop). total never exceeds MAX_INFLIGHT.
- Latency: counter state updates one cycle after the strobe. All outputs are combinational from state and the current inputs.
- Reset mid-operation: takes priority over flush, issue and wb.

Test Plan:
- Issue rd=5, then next cycle query src0 = 5 with need = 1 -> src_busy[0] = 1, raw_stall = 1. Retire wb_rd = 5: BYPASS_WB = 1 gives src_busy[0] = 0 in the same cycle; BYPASS_WB = 0 gives src_busy[0] = 0 one cycle later. inflight goes 1 -> 0.
- Issue rd=3 three times (CNT_W = 2) -> cnt = 3. Fourth issue_valid with rd=3 -> issue_ready = 0, state unchanged. One retire -> issue_ready returns to 1 the following cycle.
- MAX_INFLIGHT = 4: issue rd = 1, 2, 3, 4 -> inflight = 4, empty = 0. Issue rd=6 -> issue_ready = 0. Issue rd=0 -> issue_ready = 1 and no change.
- Same cycle: issue rd=7 and retire wb_rd=7 with cnt[7] = 0 -> cnt[7] stays 0, underflow_err = 0, inflight unchanged. Query src = 0 with need = 1 -> never busy.
- Issue rd = 8 and rd = 9, then pulse flush together with issue rd=10 -> next cycle all src_busy = 0, inflight = 0, rd=10 not recorded. A later retire wb_rd=8 -> underflow_err = 1 and remains 1 until reset.
- NWB = 2: cnt[4] = 2, both ports retire rd=4 in one cycle -> cnt[4] = 0, inflight decreases by 2. Repeat with cnt[4] = 1 -> port 1 dropped, underflow_err = 1.
